// File: rtl/comp_pkg.sv
// Shared types for the digit-serial magnitude comparator.
package comp_pkg;

    // Controller states: waiting for operands, scanning digits, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot result, bit order {L, E, S}.
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t RES_GT   = 3'b100;
    localparam cmp_res_t RES_EQ   = 3'b010;
    localparam cmp_res_t RES_LT   = 3'b001;
    localparam cmp_res_t RES_NONE = 3'b000;

    // Maps a digit-level greater/less decision onto the one-hot encoding.
    function automatic cmp_res_t res_from_flags(input logic gt, input logic lt);
        if (gt)
            return RES_GT;
        if (lt)
            return RES_LT;
        return RES_EQ;
    endfunction

endpackage

// File: rtl/comp_digit.sv
// Combinational magnitude compare of two DIGIT-bit slices, MSB has priority.
module comp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    logic [DIGIT-1:0] beq;
    logic             above;

    assign beq = ~(x ^ y);

    // Walk from the MSB down; the first unequal bit decides, lower bits are masked.
    always_comb begin
        gt    = 1'b0;
        lt    = 1'b0;
        above = 1'b1;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            gt    = gt | (above & x[i] & ~y[i]);
            lt    = lt | (above & ~x[i] & y[i]);
            above = above & beq[i];
        end
        eq = above;
    end

endmodule

// File: rtl/serial_mag_comp.sv
// Digit-serial MSB-first magnitude comparator with valid/ready on both sides.
// Signed operands are mapped to offset-binary by flipping the sign bit, so a
// single unsigned digit scan serves both modes.
module serial_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             L,
    output logic             E,
    output logic             S,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [CW-1:0]    cnt;
    cmp_res_t         res_q, res_nxt;
    cmp_res_t         first_q;
    logic             seen_q;
    logic             ov_q;

    logic             dgt, deq, dlt;
    cmp_res_t         dig_res;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] flip;

    comp_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x (sh_a[WIDTH-1 -: DIGIT]),
        .y (sh_b[WIDTH-1 -: DIGIT]),
        .gt(dgt),
        .eq(deq),
        .lt(dlt)
    );

    assign dig_res = res_from_flags(dgt, dlt);
    assign accept  = (state == IDLE) && in_valid;
    assign last    = (cnt == '0);
    assign flip    = signed_mode ? SIGN_BIT : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and the result to register when the scan finishes.
    always_comb begin
        state_nxt = state;
        res_nxt   = RES_NONE;
        case (state)
            IDLE: begin
                if (in_valid)
                    state_nxt = SCAN;
            end
            SCAN: begin
                if ((EARLY_EXIT != 0) && !deq) begin
                    state_nxt = DONE;
                    res_nxt   = dig_res;
                end else if (last) begin
                    state_nxt = DONE;
                    res_nxt   = seen_q ? first_q : dig_res;
                end
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, digit counter, first-difference latch and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a    <= '0;
            sh_b    <= '0;
            cnt     <= '0;
            seen_q  <= 1'b0;
            first_q <= RES_NONE;
            res_q   <= RES_NONE;
            ov_q    <= 1'b0;
        end else if (accept) begin
            sh_a    <= a ^ flip;
            sh_b    <= b ^ flip;
            cnt     <= CW'(NDIG - 1);
            seen_q  <= 1'b0;
            first_q <= RES_NONE;
        end else if (state == SCAN) begin
            if (state_nxt == DONE) begin
                res_q <= res_nxt;
                ov_q  <= 1'b1;
            end else begin
                sh_a <= sh_a << DIGIT;
                sh_b <= sh_b << DIGIT;
                cnt  <= cnt - 1'b1;
                if (!deq && !seen_q) begin
                    seen_q  <= 1'b1;
                    first_q <= dig_res;
                end
            end
        end else if ((state == DONE) && out_ready) begin
            res_q <= RES_NONE;
            ov_q  <= 1'b0;
        end
    end

    assign {L, E, S} = res_q;
    assign out_valid = ov_q;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: one early-exit and one fixed-latency instance,
// a timing/result model per instance, and directed plus random operations.
module tb_serial_mag_comp;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid    [2];
    logic             in_ready    [2];
    logic [WIDTH-1:0] a           [2];
    logic [WIDTH-1:0] b           [2];
    logic             signed_mode [2];
    logic             out_valid   [2];
    logic             out_ready   [2];
    logic             L           [2];
    logic             E           [2];
    logic             S           [2];
    logic             busy        [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) u_early (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .signed_mode(signed_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .L(L[0]), .E(E[0]), .S(S[0]), .busy(busy[0])
    );

    serial_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) u_fixed (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .signed_mode(signed_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .L(L[1]), .E(E[1]), .S(S[1]), .busy(busy[1])
    );

    // Reference result straight from the arithmetic meaning of the compare.
    function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic sm);
        if (sm) begin
            if ($signed(x) > $signed(y)) return 3'b100;
            if ($signed(x) < $signed(y)) return 3'b001;
            return 3'b010;
        end
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
        return 3'b010;
    endfunction

    // Reference latency: position of the most significant differing digit.
    function automatic int ref_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input bit early);
        logic [WIDTH-1:0] df;
        int p;
        df = x ^ y;
        p  = -1;
        for (int i = 0; i < WIDTH; i++)
            if (df[i]) p = i;
        if (!early || p < 0) return NDIG;
        return NDIG - p / DIGIT;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model state per instance: operation outstanding, cycles since accept, expected k and result.
    bit       m_act [2];
    int       m_age [2];
    int       m_k   [2];
    logic [2:0] m_res [2];

    // Model update on the same clock and reset as the DUTs.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d] <= 1'b0;
                m_age[d] <= 0;
                m_k[d]   <= 0;
                m_res[d] <= 3'b000;
            end else if (m_act[d]) begin
                if (m_age[d] >= m_k[d] && out_ready[d])
                    m_act[d] <= 1'b0;
                else if (m_age[d] < 1000)
                    m_age[d] <= m_age[d] + 1;
            end else if (in_valid[d]) begin
                m_act[d] <= 1'b1;
                m_age[d] <= 0;
                m_k[d]   <= ref_k(a[d], b[d], d == 0);
                m_res[d] <= ref_res(a[d], b[d], signed_mode[d]);
            end
        end
    end

    // Every cycle, away from the active edge, compare both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic exp_ov;
            exp_ov = m_act[d] && (m_age[d] >= m_k[d]);
            chk($sformatf("out_valid[%0d]", d), 32'(out_valid[d]), 32'(exp_ov));
            chk($sformatf("LES[%0d]", d), 32'({L[d], E[d], S[d]}), 32'(exp_ov ? m_res[d] : 3'b000));
            chk($sformatf("in_ready[%0d]", d), 32'(in_ready[d]), 32'(!m_act[d]));
            chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(m_act[d]));
        end
    end

    // One complete operation on instance d; returns the result and the measured latency.
    task automatic do_op(input int d, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                         input logic sm, input int stall,
                         output logic [2:0] res, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk($sformatf("idle_wait[%0d]", d), 32'(w), 32'(0));
        a[d] = aa;
        b[d] = bb;
        signed_mode[d] = sm;
        in_valid[d] = 1'b1;
        out_ready[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        a[d] = $urandom;
        b[d] = $urandom;
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (lat >= 100) chk($sformatf("result_timeout[%0d]", d), 32'(lat), 32'(NDIG));
        res = {L[d], E[d], S[d]};
        for (int i = 0; i < stall; i++) begin
            in_valid[d] = 1'b1;
            a[d] = $urandom;
            b[d] = $urandom;
            @(negedge clk);
            chk($sformatf("stall_in_ready[%0d]", d), 32'(in_ready[d]), 32'(0));
            chk($sformatf("stall_hold[%0d]", d), 32'({out_valid[d], L[d], E[d], S[d]}), 32'({1'b1, res}));
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [2:0]       r;
        int               lat;
        logic [WIDTH-1:0] ra, rb;
        logic             rsm;
        int               mode, dsel;

        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            a[d] = '0;
            b[d] = '0;
            signed_mode[d] = 1'b0;
            out_ready[d] = 1'b0;
        end

        // Pin the reference model with hand-worked values.
        chk("model_res_1", 32'(ref_res(32'h8000_0000, 32'h7FFF_FFFF, 1'b0)), 32'h4);
        chk("model_k_1", 32'(ref_k(32'h8000_0000, 32'h7FFF_FFFF, 1'b1)), 32'd1);
        chk("model_res_3s", 32'(ref_res(32'hFFFF_FFFF, 32'h0000_0001, 1'b1)), 32'h1);
        chk("model_k_eq", 32'(ref_k(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1)), 32'd8);
        chk("model_k_low", 32'(ref_k(32'h0000_0010, 32'h0000_0000, 1'b1)), 32'd7);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_out", 32'({out_valid[0], L[0], E[0], S[0], busy[0]}), 32'h0);
        chk("reset_in_ready", 32'(in_ready[0]), 32'd1);
        rst_n = 1'b1;

        do_op(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, r, lat);
        chk("t1_res", 32'(r), 32'h4);
        chk("t1_lat", 32'(lat), 32'd1);

        do_op(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, r, lat);
        chk("t2_res", 32'(r), 32'h2);
        chk("t2_lat", 32'(lat), 32'd8);

        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, r, lat);
        chk("t3_signed_res", 32'(r), 32'h1);
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, r, lat);
        chk("t3_unsigned_res", 32'(r), 32'h4);

        do_op(1, 32'h0000_0001, 32'h0000_0002, 1'b0, 0, r, lat);
        chk("t4a_res", 32'(r), 32'h1);
        chk("t4a_lat", 32'(lat), 32'd8);
        do_op(1, 32'h8000_0000, 32'h0000_0000, 1'b0, 0, r, lat);
        chk("t4b_res", 32'(r), 32'h4);
        chk("t4b_lat", 32'(lat), 32'd8);

        do_op(0, 32'h0000_0300, 32'h0000_0400, 1'b0, 5, r, lat);
        chk("t5_res", 32'(r), 32'h1);
        chk("t5_lat", 32'(lat), 32'd6);

        // Reset in the middle of a scan discards the operation.
        @(negedge clk);
        a[0] = 32'h1234_5678;
        b[0] = 32'h1234_5678;
        signed_mode[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 32'(out_valid[0]), 32'd0);
        chk("t6_les", 32'({L[0], E[0], S[0]}), 32'd0);
        chk("t6_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_op(0, 32'd5, 32'd5, 1'b0, 0, r, lat);
        chk("t6_res", 32'(r), 32'h2);
        chk("t6_lat", 32'(lat), 32'd8);

        // Random operations on both instances, checked by the per-cycle model compare.
        for (int n = 0; n < 300; n++) begin
            mode = $urandom_range(0, 3);
            ra   = $urandom;
            case (mode)
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (DIGIT * $urandom_range(0, NDIG - 1)));
                default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            endcase
            rsm  = 1'($urandom_range(0, 1));
            dsel = n % 2;
            do_op(dsel, ra, rb, rsm, $urandom_range(0, 3), r, lat);
            chk("rand_res", 32'(r), 32'(ref_res(ra, rb, rsm)));
            chk("rand_lat", 32'(lat), 32'(ref_k(ra, rb, dsel == 0)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
